// File: rtl/text_fetch.sv
// rtl/text_fetch.sv - text-mode line fetcher: char/attr map walk plus glyph row lookup, streamed as column records
module text_fetch #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          GLYPH_H      = 16,
    parameter logic [17:0] MAP_BASE     = 18'h00000,
    parameter logic [17:0] CHARROM_BASE = 18'h20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    output logic        busy,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rddata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_glyph,
    output logic [3:0]  out_fg,
    output logic [3:0]  out_bg,
    output logic        out_last
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int SCAN_W = $clog2(GLYPH_H);

    localparam logic [8:0]       LINES    = 9'(ROWS * GLYPH_H);
    localparam logic [8:0]       GH9      = 9'(GLYPH_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [17:0]      COLS18   = 18'(COLS);
    localparam logic [17:0]      GH18     = 18'(GLYPH_H);

    typedef enum logic [2:0] {
        IDLE, REQ_CHAR, DAT_CHAR, REQ_ATTR, DAT_ATTR, REQ_GLYPH, DAT_GLYPH, PUSH
    } state_t;

    state_t              state, state_n;
    logic [COL_W-1:0]    col, col_n;
    logic [ROW_W-1:0]    row, row_n;
    logic [SCAN_W-1:0]   scan, scan_n;
    logic [7:0]          char_q, char_n;
    logic [7:0]          attr_q, attr_n;
    logic [7:0]          glyph_q, glyph_n;
    logic [17:0]         addr_n;
    logic                ov_n, olast_n;
    logic [7:0]          og_n;
    logic [3:0]          ofg_n, obg_n;

    logic                line_ok;
    logic [ROW_W-1:0]    line_row;
    logic [SCAN_W-1:0]   line_scan;

    function automatic logic [17:0] char_addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        logic [17:0] entry;
        entry = 18'(r) * COLS18 + 18'(c);
        return MAP_BASE + (entry << 1);
    endfunction

    assign line_ok   = line_num < LINES;
    assign line_row  = ROW_W'(line_num / GH9);
    assign line_scan = SCAN_W'(line_num % GH9);

    assign busy    = (state != IDLE);
    assign mem_req = (state == REQ_CHAR) || (state == REQ_ATTR) || (state == REQ_GLYPH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            scan      <= '0;
            char_q    <= '0;
            attr_q    <= '0;
            glyph_q   <= '0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_glyph <= '0;
            out_fg    <= '0;
            out_bg    <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            scan      <= scan_n;
            char_q    <= char_n;
            attr_q    <= attr_n;
            glyph_q   <= glyph_n;
            mem_addr  <= addr_n;
            out_valid <= ov_n;
            out_glyph <= og_n;
            out_fg    <= ofg_n;
            out_bg    <= obg_n;
            out_last  <= olast_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        scan_n  = scan;
        char_n  = char_q;
        attr_n  = attr_q;
        glyph_n = glyph_q;
        addr_n  = mem_addr;
        ov_n    = out_valid && !out_ready;
        og_n    = out_glyph;
        ofg_n   = out_fg;
        obg_n   = out_bg;
        olast_n = out_last;

        case (state)
            IDLE: begin
                if (line_start && line_ok) begin
                    state_n = REQ_CHAR;
                    col_n   = '0;
                    row_n   = line_row;
                    scan_n  = line_scan;
                    addr_n  = char_addr(line_row, '0);
                end
            end
            REQ_CHAR:  if (mem_gnt) state_n = DAT_CHAR;
            DAT_CHAR: begin
                char_n  = mem_rddata;
                addr_n  = mem_addr + 18'd1;
                state_n = REQ_ATTR;
            end
            REQ_ATTR:  if (mem_gnt) state_n = DAT_ATTR;
            DAT_ATTR: begin
                attr_n  = mem_rddata;
                addr_n  = CHARROM_BASE + 18'(char_q) * GH18 + 18'(scan);
                state_n = REQ_GLYPH;
            end
            REQ_GLYPH: if (mem_gnt) state_n = DAT_GLYPH;
            DAT_GLYPH: begin
                glyph_n = mem_rddata;
                state_n = PUSH;
            end
            PUSH: begin
                // Output register free (or draining this cycle): hand over the record
                if (!out_valid || out_ready) begin
                    ov_n    = 1'b1;
                    og_n    = glyph_q;
                    ofg_n   = attr_q[3:0];
                    obg_n   = attr_q[7:4];
                    olast_n = (col == COL_LAST);
                    if (col != COL_LAST) begin
                        col_n   = col + 1'b1;
                        addr_n  = char_addr(row, col + 1'b1);
                        state_n = REQ_CHAR;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A new line mid-fetch wins over everything, including a pending final record
        if (line_start && state != IDLE) begin
            ov_n  = 1'b0;
            col_n = '0;
            if (line_ok) begin
                row_n   = line_row;
                scan_n  = line_scan;
                addr_n  = char_addr(line_row, '0);
                state_n = REQ_CHAR;
            end else begin
                state_n = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_text_fetch.sv
// tb/tb_text_fetch.sv - scoreboard bench for text_fetch against a memory-array reference model
module tb_text_fetch;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int GH   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [8:0]  line_num;
    logic        busy;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rddata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_glyph;
    logic [3:0]  out_fg;
    logic [3:0]  out_bg;
    logic        out_last;

    text_fetch dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_num(line_num), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rddata(mem_rddata),
        .out_valid(out_valid), .out_ready(out_ready), .out_glyph(out_glyph),
        .out_fg(out_fg), .out_bg(out_bg), .out_last(out_last)
    );

    always #20 clk = ~clk;

    logic [7:0]  mem [0:262143];
    logic [16:0] exp_q[$];
    logic [17:0] addr_log[$];
    int n_cmp = 0, n_err = 0, n_pop = 0;
    bit gnt_auto = 1'b1;
    int gnt_pct  = 100;
    bit rdy_auto = 1'b1;
    int rdy_pct  = 100;
    logic        pend = 1'b0;
    logic [17:0] pend_addr = '0;
    logic        prev_ls = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] model(input int ln, input int c);
        int e;
        logic [7:0] ch, at, g;
        e  = (ln / GH) * COLS + c;
        ch = mem[2 * e];
        at = mem[2 * e + 1];
        g  = mem[32'h20000 + int'(ch) * GH + (ln % GH)];
        return {g, at[3:0], at[7:4], (c == COLS - 1)};
    endfunction

    // Memory slave: one-cycle read latency, optional random grant
    always @(negedge clk) begin
        mem_rddata = pend ? mem[pend_addr] : 8'($urandom);
        if (gnt_auto) mem_gnt = ($urandom_range(99) < gnt_pct);
        #3;
        if (pend && !prev_ls && !rst) begin
            check("dat_addr_hold", 32'(mem_addr), 32'(pend_addr));
            check("dat_req_low", 32'(mem_req), 32'd0);
        end
        pend      = mem_req && mem_gnt && !rst;
        pend_addr = mem_addr;
        prev_ls   = line_start;
        if (pend) addr_log.push_back(mem_addr);
    end

    always @(negedge clk) begin
        if (rdy_auto) out_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor: every accepted record is popped from the scoreboard
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_record: got %0h expected none", {out_glyph, out_fg, out_bg, out_last});
            end else begin
                check("record", 32'({out_glyph, out_fg, out_bg, out_last}), 32'(exp_q.pop_front()));
            end
            n_pop++;
        end
    end

    task automatic pulse(input int n);
        line_start = 1'b1;
        line_num   = 9'(n);
        #2;
        if (busy) exp_q.delete();
        if (n < ROWS * GH)
            for (int c = 0; c < COLS; c++) exp_q.push_back(model(n, c));
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while ((busy || out_valid || exp_q.size() != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("line_done_in_time", 32'(k < bound), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_glyph"}, 32'(out_glyph), 32'd0);
        check({tag, "_out_fg"}, 32'(out_fg), 32'd0);
        check({tag, "_out_bg"}, 32'(out_bg), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        #3600000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k, p0, a;
        bit pb, found;
        logic [16:0] held;

        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        for (int i = 0; i < 2 * ROWS * COLS; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256 * GH; i++) mem[32'h20000 + i] = 8'($urandom);
        mem[0]       = 8'h41;
        mem[1]       = 8'h1E;
        mem[32'h20413] = 8'h18;

        rst = 1'b1; line_start = 1'b0; line_num = '0; mem_gnt = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // First line: addresses, latency, first record
        addr_log.delete();
        p0 = n_pop;
        pulse(3);
        check("start_req", 32'(mem_req), 32'd1);
        check("start_addr", 32'(mem_addr), 32'h00000);
        k = 1;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        check("first_valid_latency", 32'(k), 32'd8);
        check("first_glyph", 32'(out_glyph), 32'h18);
        check("first_fg", 32'(out_fg), 32'hE);
        check("first_bg", 32'(out_bg), 32'h1);
        check("first_last", 32'(out_last), 32'd0);
        wait_done(20000);
        check("addr_seq_len", 32'(addr_log.size() >= 3), 32'd1);
        if (addr_log.size() >= 3) begin
            check("addr_char", 32'(addr_log[0]), 32'h00000);
            check("addr_attr", 32'(addr_log[1]), 32'h00001);
            check("addr_glyph", 32'(addr_log[2]), 32'h20413);
        end
        check("line3_count", 32'(n_pop - p0), 32'd80);

        // Last text row: out_last, busy fall and col 79 address
        addr_log.delete();
        p0 = n_pop;
        pulse(479);
        pb = 1'b1;
        k = 0;
        while (!(out_valid && out_last) && k < 2000) begin pb = busy; @(negedge clk); k++; end
        check("last_busy_low", 32'(busy), 32'd0);
        check("busy_before_last", 32'(pb), 32'd1);
        wait_done(20000);
        found = 1'b0;
        foreach (addr_log[i]) if (addr_log[i] == 18'h012BE) found = 1'b1;
        check("col79_char_addr", 32'(found), 32'd1);
        check("line479_count", 32'(n_pop - p0), 32'd80);

        // Unstalled line duration
        pulse(100);
        k = 1;
        while (busy && k < 2000) begin @(negedge clk); k++; end
        check("line_cycles", 32'(k), 32'd561);
        wait_done(20000);

        // Grant held low for 5 cycles in REQ_ATTR of column 0
        gnt_auto = 1'b0;
        mem_gnt  = 1'b1;
        pulse(200);
        @(negedge clk);
        @(negedge clk);
        k = 3;
        mem_gnt = 1'b0;
        repeat (5) begin
            #4;
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", 32'(mem_addr), 32'((200 / GH) * COLS * 2 + 1));
            @(negedge clk);
            k++;
        end
        mem_gnt = 1'b1;
        while (busy && k < 2000) begin @(negedge clk); k++; end
        check("stalled_line_cycles", 32'(k), 32'd566);
        gnt_auto = 1'b1;
        wait_done(20000);

        // Consumer stall after the first record
        rdy_auto  = 1'b0;
        out_ready = 1'b0;
        p0 = n_pop;
        pulse(37);
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        held = {out_glyph, out_fg, out_bg, out_last};
        check("held_first_is_col0", 32'(held), 32'(model(37, 0)));
        repeat (20) begin
            @(negedge clk);
            #2;
            check("held_record", 32'({out_valid, out_glyph, out_fg, out_bg, out_last}), 32'({1'b1, held}));
        end
        check("wait_in_push_req", 32'(mem_req), 32'd0);
        check("wait_in_push_busy", 32'(busy), 32'd1);
        check("no_pop_while_stalled", 32'(n_pop - p0), 32'd0);
        @(negedge clk);
        rdy_auto = 1'b1;
        rdy_pct  = 60;
        wait_done(20000);
        check("line37_count", 32'(n_pop - p0), 32'd80);
        rdy_pct = 100;

        // Restart from DAT_ATTR
        p0 = n_pop;
        pulse(5);
        repeat (3) @(negedge clk);
        pulse(16);
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h000A0);
        wait_done(20000);
        check("restart_count", 32'(n_pop - p0), 32'd80);

        // Restart coinciding with the final PUSH
        p0 = n_pop;
        pulse(64);
        repeat (559) @(negedge clk);
        pulse(65);
        wait_done(20000);
        check("final_push_restart_count", 32'(n_pop - p0), 32'd159);

        // Randomized lines with random grant/ready
        for (int it = 0; it < 6; it++) begin
            gnt_pct = $urandom_range(100, 40);
            rdy_pct = $urandom_range(100, 30);
            p0 = n_pop;
            pulse($urandom_range(ROWS * GH - 1, 0));
            wait_done(20000);
            check("random_line_count", 32'(n_pop - p0), 32'd80);
        end
        for (int it = 0; it < 3; it++) begin
            pulse($urandom_range(ROWS * GH - 1, 0));
            a = $urandom_range(300, 1);
            repeat (a) @(negedge clk);
            pulse($urandom_range(ROWS * GH - 1, 0));
            wait_done(20000);
        end
        gnt_pct = 100;
        rdy_pct = 100;

        // Out-of-range line numbers are ignored
        pulse(480);
        repeat (10) begin
            #2;
            check("oor_busy", 32'(busy), 32'd0);
            check("oor_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        pulse(511);
        #2 check("oor511_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset mid-line, then recovery
        pulse(7);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2 check_idle_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p0 = n_pop;
        pulse(9);
        wait_done(20000);
        check("after_reset_count", 32'(n_pop - p0), 32'd80);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
